// File: rtl/dmem_pkg.sv
// Shared types and helpers for the multi-cycle MEM-stage data memory.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  localparam logic [3:0] SZ_B = 4'd1;
  localparam logic [3:0] SZ_H = 4'd2;
  localparam logic [3:0] SZ_W = 4'd4;
  localparam logic [3:0] SZ_D = 4'd8;

  // True when size is a power-of-two transfer and addr is naturally aligned to it.
  function automatic logic size_legal(input logic [3:0] size, input logic [63:0] addr);
    logic ok_size;
    ok_size = (size == SZ_B) || (size == SZ_H) || (size == SZ_W) || (size == SZ_D);
    return ok_size && ((addr[3:0] & (size - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bundle between the MEM stage (master) and the data memory (slave).
interface dmem_responder_if;

  logic        req_valid;
  logic        req_write;
  logic [63:0] req_addr;
  logic [3:0]  req_size;
  logic [63:0] req_wdata;
  logic        req_ready;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_size, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_size, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/dmem_byte_array.sv
// Byte-addressable storage split into eight byte lanes of one 64-bit word each;
// big-endian, size-masked write and registered read.
module dmem_byte_array #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [3:0]            size_i,
  input  logic [63:0]           wdata_i,
  output logic [63:0]           rdata_o
);

  localparam int DEPTH = 2 ** (ADDR_WIDTH - 3);

  logic [ADDR_WIDTH-4:0] word;
  logic [2:0]            off;
  logic [7:0]            lane_we;
  logic [63:0]           lane_wdata;
  logic [63:0]           lane_rd;
  logic [2:0]            idx;
  logic [3:0]            sh;

  assign word = addr_i[ADDR_WIDTH-1:3];
  assign off  = addr_i[2:0];

  // Aligned accesses never leave their 8-byte word, so lane l carries
  // transfer byte (l - off), which sits (size-1-idx) bytes above the LSB.
  always_comb begin
    lane_we    = '0;
    lane_wdata = '0;
    rdata_o    = '0;
    idx        = '0;
    sh         = '0;
    for (int l = 0; l < 8; l++) begin
      idx = 3'(l) - off;
      if ({1'b0, idx} < size_i) begin
        sh                      = size_i - 4'd1 - {1'b0, idx};
        lane_we[l]              = we_i;
        lane_wdata[8*l +: 8]    = wdata_i[{sh, 3'b000} +: 8];
        rdata_o[{sh, 3'b000} +: 8] = lane_rd[8*l +: 8];
      end
    end
  end

  for (genvar gi = 0; gi < 8; gi++) begin : g_lane
    logic [7:0] bank [DEPTH];
    logic [7:0] rd_q;

    always_ff @(posedge clk) begin
      if (lane_we[gi]) begin
        bank[word] <= lane_wdata[8*gi +: 8];
      end
      rd_q <= bank[word];
    end

    assign lane_rd[8*gi +: 8] = rd_q;
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle responder for MEM-stage loads/stores: handshake FSM, latency
// counter, captured request and legality check around dmem_byte_array.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 3
) (
  input  logic             clk,
  input  logic             reset,
  dmem_responder_if.slave  bus
);

  state_e                state_q;
  logic [3:0]            cnt_q;
  logic                  write_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [3:0]            size_q;
  logic [63:0]           wdata_q;
  logic                  err_q;
  logic                  resp_valid_q;
  logic                  resp_err_q;

  logic                  accept_d;
  logic                  err_d;
  logic                  to_resp_d;
  logic                  use_bus_d;
  logic                  we_d;
  logic [ADDR_WIDTH-1:0] arr_addr_d;
  logic [3:0]            arr_size_d;
  logic [63:0]           arr_wdata_d;
  logic [63:0]           arr_rdata;

  assign bus.req_ready = (state_q == IDLE) && !reset;
  assign accept_d      = bus.req_valid && bus.req_ready;
  assign err_d         = !size_legal(bus.req_size, bus.req_addr)
                         || (bus.req_addr[63:ADDR_WIDTH] != '0);

  assign to_resp_d = ((state_q == IDLE) && accept_d && (LATENCY == 1))
                   || ((state_q == WAIT) && (cnt_q == 4'd1));

  // With LATENCY==1 the commit edge is the acceptance edge, so the array
  // must see the live request rather than the captured copy.
  assign use_bus_d   = (state_q == IDLE);
  assign arr_addr_d  = use_bus_d ? bus.req_addr[ADDR_WIDTH-1:0] : addr_q;
  assign arr_size_d  = use_bus_d ? bus.req_size : size_q;
  assign arr_wdata_d = use_bus_d ? bus.req_wdata : wdata_q;
  assign we_d        = !reset && to_resp_d
                       && (use_bus_d ? (bus.req_write && !err_d) : (write_q && !err_q));

  dmem_byte_array #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_array (
    .clk     (clk),
    .we_i    (we_d),
    .addr_i  (arr_addr_d),
    .size_i  (arr_size_d),
    .wdata_i (arr_wdata_d),
    .rdata_o (arr_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      size_q       <= '0;
      wdata_q      <= '0;
      err_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept_d) begin
            write_q <= bus.req_write;
            addr_q  <= bus.req_addr[ADDR_WIDTH-1:0];
            size_q  <= bus.req_size;
            wdata_q <= bus.req_wdata;
            err_q   <= err_d;
            if (LATENCY > 1) begin
              cnt_q   <= 4'(LATENCY - 1);
              state_q <= WAIT;
            end else begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= err_d;
            end
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= err_q;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = (resp_valid_q && !resp_err_q && !write_q) ? arr_rdata : '0;

endmodule
